// File: rtl/ex39_pkg.sv
// Shared sizing and operand type for the ex39 subtractor slice.
// No logic, so no latency and no flow control.
package ex39_pkg;

    localparam int EX39_WIDTH     = 5;
    localparam int EX39_CNT_WIDTH = 8;

    typedef logic [EX39_WIDTH-1:0] operand_t;

endpackage

// File: rtl/ex39_full_sub.sv
// 1-bit full subtractor cell: d = x - y - bin, with borrow-out.
// Purely combinational, no flow control.
module ex39_full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/ex39_subtractor.sv
// Unsigned ripple subtractor with registered copy and saturating borrow counter; ovf port via EX39_SIGNED_OVF_EN.
// diff/borrow(/ovf) are combinational; diff_q/borrow_q/borrow_cnt update one clk after capture.
// No backpressure: en gates capture, registers hold while en=0, rst wins over en.
module ex39_subtractor
    import ex39_pkg::*;
#(
    parameter int WIDTH     = EX39_WIDTH,
    parameter int CNT_WIDTH = EX39_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 en,
    output logic [WIDTH-1:0]     diff,
    output logic                 borrow,
    output logic [WIDTH-1:0]     diff_q,
    output logic                 borrow_q,
    output logic [CNT_WIDTH-1:0] borrow_cnt
`ifdef EX39_SIGNED_OVF_EN
    ,
    output logic                 ovf
`endif
);

    logic [WIDTH:0] bchain;

    assign bchain[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ex39_full_sub u_fs (
            .x    (a[i]),
            .y    (b[i]),
            .bin  (bchain[i]),
            .d    (diff[i]),
            .bout (bchain[i+1])
        );
    end

    assign borrow = bchain[WIDTH];

`ifdef EX39_SIGNED_OVF_EN
    // Operands of opposite sign whose result sign differs from the minuend's.
    assign ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
`endif

    logic [WIDTH-1:0]     diff_d;
    logic                 borrow_d;
    logic [CNT_WIDTH-1:0] borrow_cnt_d;
    logic [CNT_WIDTH-1:0] borrow_cnt_q;

    always_comb begin
        diff_d       = diff_q;
        borrow_d     = borrow_q;
        borrow_cnt_d = borrow_cnt_q;
        if (en) begin
            diff_d   = diff;
            borrow_d = borrow;
            if (borrow && (borrow_cnt_q != {CNT_WIDTH{1'b1}})) begin
                borrow_cnt_d = borrow_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            diff_q       <= '0;
            borrow_q     <= 1'b0;
            borrow_cnt_q <= '0;
        end else begin
            diff_q       <= diff_d;
            borrow_q     <= borrow_d;
            borrow_cnt_q <= borrow_cnt_d;
        end
    end

    assign borrow_cnt = borrow_cnt_q;

endmodule

// File: tb/tb_ex39_subtractor.sv
// Directed-vector bench for ex39_subtractor; signed overflow checks only when EX39_SIGNED_OVF_EN is defined.
module tb_ex39_subtractor;

    logic       clk;
    logic       rst;
    logic [4:0] a;
    logic [4:0] b;
    logic       en;
    logic [4:0] diff;
    logic       borrow;
    logic [4:0] diff_q;
    logic       borrow_q;
    logic [7:0] borrow_cnt;
`ifdef EX39_SIGNED_OVF_EN
    logic       ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    ex39_subtractor dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .en         (en),
        .diff       (diff),
        .borrow     (borrow),
        .diff_q     (diff_q),
        .borrow_q   (borrow_q),
        .borrow_cnt (borrow_cnt)
`ifdef EX39_SIGNED_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic comb(input logic [4:0] va, input logic [4:0] vb,
                        input logic [4:0] exp_d, input logic exp_b);
        a = va;
        b = vb;
        #1;
        check("diff", 32'(diff), 32'(exp_d));
        check("borrow", 32'(borrow), 32'(exp_b));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic regs(input string tag, input logic [4:0] exp_d,
                        input logic exp_b, input logic [7:0] exp_c);
        check({tag, ".diff_q"}, 32'(diff_q), 32'(exp_d));
        check({tag, ".borrow_q"}, 32'(borrow_q), 32'(exp_b));
        check({tag, ".borrow_cnt"}, 32'(borrow_cnt), 32'(exp_c));
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        a   = '0;
        b   = '0;

        // Combinational path, directed vectors
        comb(5'd20, 5'd15, 5'd5,  1'b0);
        comb(5'd10, 5'd5,  5'd5,  1'b0);
        comb(5'd17, 5'd17, 5'd0,  1'b0);
        comb(5'd3,  5'd7,  5'd28, 1'b1);
        comb(5'd0,  5'd31, 5'd1,  1'b1);
        comb(5'd31, 5'd0,  5'd31, 1'b0);
        comb(5'd16, 5'd17, 5'd31, 1'b1);

        // Reset clears registers
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        tick();
        rst = 1'b0;
        en  = 1'b0;
        regs("reset", 5'd0, 1'b0, 8'd0);

        // Combinational outputs follow inputs while rst is held
        rst = 1'b1;
        comb(5'd9, 5'd4, 5'd5, 1'b0);
        tick();
        rst = 1'b0;

        // Capture a borrow case: one-cycle latency, then three edges
        a  = 5'd3;
        b  = 5'd7;
        en = 1'b1;
        tick();
        regs("cap1", 5'd28, 1'b1, 8'd1);
        tick();
        tick();
        regs("cap3", 5'd28, 1'b1, 8'd3);

        // Hold while en=0 and operands change
        en = 1'b0;
        a  = 5'd20;
        b  = 5'd15;
        tick();
        a = 5'd1;
        b = 5'd30;
        tick();
        regs("hold", 5'd28, 1'b1, 8'd3);

        // Non-borrow capture leaves counter unchanged
        a  = 5'd20;
        b  = 5'd15;
        en = 1'b1;
        tick();
        regs("noborrow", 5'd5, 1'b0, 8'd3);

        // Saturation: 3 + 252 reaches 255, further borrows hold it
        a = 5'd0;
        b = 5'd31;
        repeat (251) tick();
        check("cnt254", 32'(borrow_cnt), 32'd254);
        tick();
        check("cnt255", 32'(borrow_cnt), 32'd255);
        repeat (48) tick();
        regs("sat", 5'd1, 1'b1, 8'd255);

        // rst wins over en
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en  = 1'b0;
        regs("rst_en", 5'd0, 1'b0, 8'd0);

`ifdef EX39_SIGNED_OVF_EN
        a = 5'd15; b = 5'd16; #1;   // 15 - (-16) = 31
        check("ovf_15_16", 32'(ovf), 32'd1);
        a = 5'd20; b = 5'd15; #1;   // -12 - 15 = -27
        check("ovf_20_15", 32'(ovf), 32'd1);
        a = 5'd5; b = 5'd3; #1;
        check("ovf_5_3", 32'(ovf), 32'd0);
        a = 5'd16; b = 5'd1; #1;    // -16 - 1 = -17
        check("ovf_16_1", 32'(ovf), 32'd1);
`endif

        // Exhaustive sweep against an arithmetic model
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 32; j++) begin
                int s;
                a = 5'(i);
                b = 5'(j);
                #1;
                check("sweep.diff", 32'(diff), 32'((i - j + 32) % 32));
                check("sweep.borrow", 32'(borrow), (i < j) ? 32'd1 : 32'd0);
`ifdef EX39_SIGNED_OVF_EN
                s = ((i >= 16) ? i - 32 : i) - ((j >= 16) ? j - 32 : j);
                check("sweep.ovf", 32'(ovf), (s < -16 || s > 15) ? 32'd1 : 32'd0);
`else
                s = 0;
`endif
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
